// File: rtl/mmu_feeder.sv
// Sequencer and diagonal skew stage in front of the systolic MMU.
// Loads a DEPTH-row weight tile (control=1), streams activation vectors with
// lane i delayed i+1 cycles, drains the skew and tags valid acc_out samples.
module mmu_feeder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned RES_LAT   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       wt_in_valid,
    output logic                       wt_in_ready,
    input  logic [DEPTH*BIT_WIDTH-1:0] wt_in_data,
    input  logic                       act_in_valid,
    output logic                       act_in_ready,
    input  logic [DEPTH*BIT_WIDTH-1:0] act_in_data,
    input  logic                       act_in_last,
    output logic                       mmu_control,
    output logic [DEPTH*BIT_WIDTH-1:0] mmu_wt_arr,
    output logic [DEPTH*BIT_WIDTH-1:0] mmu_data_arr,
    output logic                       res_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned CntW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned VecW = DEPTH * BIT_WIDTH;

    typedef enum logic [1:0] {StIdle, StLoad, StStream, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   row_cnt_q, row_cnt_d;
    logic [CntW-1:0]   drain_cnt_q, drain_cnt_d;
    logic              done_q, done_d;
    logic              ctl_q, ctl_d;
    logic [VecW-1:0]   wt_q, wt_d;
    logic [RES_LAT:0]  res_pipe_q;
    logic              wt_fire;
    logic              act_fire;

    // Ready depends on state only, so upstream never sees a comb path from valid.
    assign wt_in_ready  = (state_q == StLoad);
    assign act_in_ready = (state_q == StStream);
    assign wt_fire      = wt_in_valid & wt_in_ready;
    assign act_fire     = act_in_valid & act_in_ready;

    assign mmu_control = ctl_q;
    assign mmu_wt_arr  = wt_q;
    assign done        = done_q;
    assign busy        = (state_q != StIdle);
    assign res_valid   = res_pipe_q[RES_LAT];

    // Next-state, counters and registered weight-path outputs.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        ctl_d       = 1'b0;
        wt_d        = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoad;
                    row_cnt_d = '0;
                end
            end
            StLoad: begin
                // A bubble leaves control and weights at 0, freezing the array.
                if (wt_fire) begin
                    ctl_d = 1'b1;
                    wt_d  = wt_in_data;
                    if (row_cnt_q == CntW'(DEPTH - 1)) begin
                        state_d   = StStream;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + CntW'(1);
                    end
                end
            end
            StStream: begin
                if (act_fire && act_in_last) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end
            end
            StDrain: begin
                // Stay until the deepest lane has emitted the last vector's element.
                if (drain_cnt_q == CntW'(DEPTH - 1)) begin
                    state_d     = StIdle;
                    drain_cnt_d = '0;
                    done_d      = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and weight-path output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            ctl_q       <= 1'b0;
            wt_q        <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            ctl_q       <= ctl_d;
            wt_q        <= wt_d;
        end
    end

    // Result tag pipe; keeps shifting in IDLE so tail results are still marked.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_pipe_q <= '0;
        end else begin
            res_pipe_q[0] <= act_fire;
            for (int unsigned k = 1; k <= RES_LAT; k++) begin
                res_pipe_q[k] <= res_pipe_q[k-1];
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        logic [BIT_WIDTH-1:0] sr_q [i+1];

        // Lane i shift register of length i+1; zeros enter on bubbles and in DRAIN.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned k = 0; k <= i; k++) begin
                    sr_q[k] <= '0;
                end
            end else begin
                sr_q[0] <= act_fire ? act_in_data[i*BIT_WIDTH +: BIT_WIDTH] : '0;
                for (int unsigned k = 1; k <= i; k++) begin
                    sr_q[k] <= sr_q[k-1];
                end
            end
        end

        assign mmu_data_arr[i*BIT_WIDTH +: BIT_WIDTH] = sr_q[i];
    end

endmodule
